round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller for the memory pattern game.
//  - On start: copies one PAT_LEN-symbol pattern from a block-memory bank into a local register file.
//  - Each round: displays the first round_len symbols on the slow level tick, then opens a timed input window.
//  - Checks each player press against the pattern, grows the round on success, ends the game on error/timeout.
//  - Sits between the menu FSM / level clock divider and the block_mem + seven-segment display datapath.
// PARAMETERS
//  PAT_LEN     50  symbols per stored pattern (max round length)
//  SYM_W       3   symbol code width (0 UP,1 DOWN,2 LEFT,3 RIGHT,4 MID)
//  ADDR_W      8   block memory address width
//  BANK_STRIDE 50  address offset between banks
//  START_LEN   1   round_len of first round
//  TIME_TICKS  3   extra input-window ticks beyond round_len
//  GOOD_TICKS  2   ticks GOOD message is held between rounds
// PORTS
//  clk        in  1       system clock
//  rst_n      in  1       synchronous active-low reset
//  start      in  1       1-cycle pulse from menu: begin new game
//  bank_sel   in  2       pattern bank, sampled on accepted start
//  tick       in  1       1-cycle enable at level speed
//  mem_addr   out ADDR_W  block memory read address
//  mem_rd     out 1       read strobe; mem_data valid exactly 1 cycle later
//  mem_data   in  SYM_W   symbol read from block memory
//  btn_valid  in  1       1-cycle pulse per debounced press
//  btn_code   in  SYM_W   symbol of pressed button, valid with btn_valid
//  show_en    out 1       display pattern symbol show_sym
//  show_sym   out SYM_W   symbol currently shown / echoed
//  msg_sel    out 2       0 BLANK, 1 ECHO, 2 GOOD, 3 LOSE
//  round_len  out 6       current round length
//  score      out 6       completed rounds
//  busy       out 1       high in LOAD..GOOD
//  game_over  out 1       high in LOSE or DONE
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-low. All outputs 0 (msg_sel BLANK); state IDLE; pattern file not cleared.
//  States: IDLE, LOAD, SHOW_OFF, SHOW_ON, INPUT, GOOD, LOSE, DONE.
//  IDLE/LOSE/DONE + start -> LOAD:
//   - latch bank_sel; clear score and game_over; i=0.
//   - start in any other state is ignored.
//  LOAD:
//   - mem_rd=1 with mem_addr=bank*BANK_STRIDE+i for i=0..PAT_LEN-1, one address per cycle.
//   - capture pat[i] from mem_data the following cycle.
//   - after last capture (PAT_LEN+1 cycles total): round_len=START_LEN, idx=0 -> SHOW_OFF.
//  SHOW phase (advances only on tick):
//   - SHOW_OFF: show_en=0, msg BLANK; on tick -> SHOW_ON.
//   - SHOW_ON: show_en=1, show_sym=pat[idx].
//   - On tick: if idx<round_len-1 then idx++, -> SHOW_OFF.
//   - Else vidx=0, timer=round_len+TIME_TICKS -> INPUT.
//  INPUT:
//   - btn_valid with btn_code==pat[vidx]: msg ECHO, show_sym=btn_code, vidx++.
//   - If that was press round_len: score=round_len, gcnt=GOOD_TICKS -> GOOD.
//   - btn_valid mismatch -> LOSE.
//   - tick decrements timer; tick while timer==0 -> LOSE.
//   - btn_valid and tick in same cycle: press evaluated first; timer not decremented that cycle.
//  GOOD: msg GOOD; gcnt decremented on tick; at 0:
//   - if round_len==PAT_LEN -> DONE (msg GOOD, game_over=1);
//   - else round_len++, idx=0 -> SHOW_OFF.
//  LOSE: msg LOSE, game_over=1, score frozen.
//  Inputs ignored: btn_valid outside INPUT; tick in IDLE/LOAD/LOSE/DONE.
//  Widths: timer 7 bits (max PAT_LEN+TIME_TICKS<128); round_len/score saturate at PAT_LEN.
//  Reset mid-operation: abandons load/round immediately; next round only via start.
// STRUCTURE
//  Shared package (game_pkg):
//   - symbol codes, msg_sel encodings, state enum
//   - NUM_BANKS=4, default PAT_LEN/BANK_STRIDE
//  Sub-module pattern_loader: LOAD address counter, mem_rd pipeline, pat write port.
//  FSM, timer and compare stay in round_sequencer.
// TESTING
//  1. Reset, start, bank 2, mem model returns addr[2:0]%5
//      -> mem_addr 100..149 consecutive, mem_rd 50 cycles, pat matches.
//  2. Round 1 shows pat[0] for 1 tick after 1 blank tick
//      -> correct press: GOOD 2 ticks, score=1, round_len=2.
//  3. Round 2, first press correct, second wrong -> msg LOSE, game_over=1, score=1.
//  4. Round 1, no press -> LOSE on tick after timer reaches 0 (tick 5 of INPUT).
//  5. Correct final press in same cycle as expiring tick -> GOOD, not LOSE.
//  6. rst_n low mid-LOAD -> outputs 0 next cycle; start pulse during SHOW ignored.

Source files
------------

// File: rtl/round_sequencer_pkg.sv
// Shared definitions for the memory-game round controller.
// Holds symbol codes, display message encodings, FSM state codes,
// datapath widths and default geometry of the pattern memory.
package round_sequencer_pkg;

  localparam int SYM_W           = 3;   // symbol code width
  localparam int ADDR_W          = 8;   // block memory address width
  localparam int IDX_W           = 6;   // pattern index / round length width
  localparam int TIMER_W         = 7;   // input-window timer width
  localparam int GCNT_W          = 4;   // GOOD hold counter width
  localparam int NUM_BANKS       = 4;
  localparam int BANK_W          = $clog2(NUM_BANKS);
  localparam int DEF_PAT_LEN     = 50;
  localparam int DEF_BANK_STRIDE = 50;

  typedef enum logic [SYM_W-1:0] {
    SYM_UP    = 3'd0,
    SYM_DOWN  = 3'd1,
    SYM_LEFT  = 3'd2,
    SYM_RIGHT = 3'd3,
    SYM_MID   = 3'd4
  } sym_e;

  // msg_sel encodings for the seven-segment message mux
  localparam logic [1:0] MSG_BLANK = 2'd0;
  localparam logic [1:0] MSG_ECHO  = 2'd1;
  localparam logic [1:0] MSG_GOOD  = 2'd2;
  localparam logic [1:0] MSG_LOSE  = 2'd3;

  // FSM state codes; LOAD..GOOD are contiguous so busy is a range test
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHOW_OFF = 3'd2;
  localparam logic [2:0] ST_SHOW_ON  = 3'd3;
  localparam logic [2:0] ST_INPUT    = 3'd4;
  localparam logic [2:0] ST_GOOD     = 3'd5;
  localparam logic [2:0] ST_LOSE     = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  function automatic logic state_is_busy(input logic [2:0] st);
    return (st >= ST_LOAD) && (st <= ST_GOOD);
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Bus bundle between the round controller and its datapath neighbours.
//   mem_addr  block memory read address (controller -> memory)
//   mem_rd    read strobe, data returns one cycle later
//   mem_data  symbol read from block memory
//   btn_valid one-cycle pulse per debounced press
//   btn_code  symbol of the pressed button, valid with btn_valid
// master: the round controller; slave: memory / button side.
interface round_sequencer_if;
  import round_sequencer_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [SYM_W-1:0]  mem_data;
  logic              btn_valid;
  logic [SYM_W-1:0]  btn_code;

  modport master (
    output mem_addr, mem_rd,
    input  mem_data, btn_valid, btn_code
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_data, btn_valid, btn_code
  );
endinterface

// File: rtl/round_sequencer_loader.sv
// Pattern loader: streams PAT_LEN symbols from one memory bank into the
// controller's pattern register file.
//   clk, rst_n  clock, synchronous active-low reset
//   load_go     one-cycle pulse: start a load from bank
//   bank        bank number, sampled with load_go
//   mem_rd      read strobe, one per pattern index
//   mem_addr    bank*BANK_STRIDE + index while reading, else 0
//   mem_data    returned symbol (valid one cycle after mem_rd)
//   wr_en/wr_addr/wr_data  pattern file write port
//   done        pulses with the last pattern write
module round_sequencer_loader
  import round_sequencer_pkg::*;
#(
  parameter int PAT_LEN     = DEF_PAT_LEN,
  parameter int BANK_STRIDE = DEF_BANK_STRIDE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_go,
  input  logic [BANK_W-1:0] bank,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [SYM_W-1:0]  mem_data,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_addr,
  output logic [SYM_W-1:0]  wr_data,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

  logic              rd_active_reg;
  logic [IDX_W-1:0]  rd_idx_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              cap_valid_reg;
  logic [IDX_W-1:0]  cap_idx_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_active_reg <= 1'b0;
      rd_idx_reg    <= '0;
      base_reg      <= '0;
      cap_valid_reg <= 1'b0;
      cap_idx_reg   <= '0;
    end else begin
      // capture stage trails the read stage by exactly the memory latency
      cap_valid_reg <= rd_active_reg;
      cap_idx_reg   <= rd_idx_reg;
      if (load_go) begin
        rd_active_reg <= 1'b1;
        rd_idx_reg    <= '0;
        base_reg      <= ADDR_W'(int'(bank) * BANK_STRIDE);
      end else if (rd_active_reg) begin
        if (rd_idx_reg == LAST_IDX) begin
          rd_active_reg <= 1'b0;
        end else begin
          rd_idx_reg <= rd_idx_reg + 1'b1;
        end
      end
    end
  end

  assign mem_rd   = rd_active_reg;
  assign mem_addr = rd_active_reg ? (base_reg + ADDR_W'(rd_idx_reg)) : '0;
  assign wr_en    = cap_valid_reg;
  assign wr_addr  = cap_idx_reg;
  assign wr_data  = mem_data;
  assign done     = cap_valid_reg && (cap_idx_reg == LAST_IDX);

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller for the memory pattern game.
// Loads a pattern from a memory bank, shows a growing prefix of it on the
// level tick, then checks the player's presses inside a timed window.
//   clk, rst_n  clock, synchronous active-low reset
//   start       menu pulse: new game (accepted in IDLE/LOSE/DONE only)
//   bank_sel    pattern bank, sampled on accepted start
//   tick        level-speed enable pulse
//   bus         memory read port and button inputs (master side)
//   show_en     pattern symbol show_sym is being displayed
//   show_sym    shown pattern symbol, or echo of the last good press
//   msg_sel     BLANK / ECHO / GOOD / LOSE
//   round_len   current round length
//   score       completed rounds
//   busy        game in progress (LOAD..GOOD)
//   game_over   LOSE or DONE
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int PAT_LEN     = DEF_PAT_LEN,
  parameter int BANK_STRIDE = DEF_BANK_STRIDE,
  parameter int START_LEN   = 1,
  parameter int TIME_TICKS  = 3,
  parameter int GOOD_TICKS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BANK_W-1:0]     bank_sel,
  input  logic                  tick,
  round_sequencer_if.master     bus,
  output logic                  show_en,
  output logic [SYM_W-1:0]      show_sym,
  output logic [1:0]            msg_sel,
  output logic [IDX_W-1:0]      round_len,
  output logic [IDX_W-1:0]      score,
  output logic                  busy,
  output logic                  game_over
);

  localparam logic [IDX_W-1:0]   PAT_LEN_C   = IDX_W'(PAT_LEN);
  localparam logic [IDX_W-1:0]   START_LEN_C = IDX_W'(START_LEN);
  localparam logic [TIMER_W-1:0] TIME_C      = TIMER_W'(TIME_TICKS);
  localparam logic [GCNT_W-1:0]  GOOD_C      = GCNT_W'(GOOD_TICKS);

  logic [2:0]         state_reg,     state_next;
  logic [IDX_W-1:0]   idx_reg,       idx_next;
  logic [IDX_W-1:0]   vidx_reg,      vidx_next;
  logic [TIMER_W-1:0] timer_reg,     timer_next;
  logic [GCNT_W-1:0]  gcnt_reg,      gcnt_next;
  logic [IDX_W-1:0]   round_len_reg, round_len_next;
  logic [IDX_W-1:0]   score_reg,     score_next;
  logic [SYM_W-1:0]   echo_sym_reg,  echo_sym_next;
  logic               echo_flag_reg, echo_flag_next;

  // pattern register file; deliberately not reset
  logic [SYM_W-1:0]   pat_mem [PAT_LEN];

  logic               load_go;
  logic               ld_wr_en;
  logic [IDX_W-1:0]   ld_wr_addr;
  logic [SYM_W-1:0]   ld_wr_data;
  logic               ld_done;

  assign load_go = start &&
                   ((state_reg == ST_IDLE) || (state_reg == ST_LOSE) || (state_reg == ST_DONE));

  round_sequencer_loader #(
    .PAT_LEN     (PAT_LEN),
    .BANK_STRIDE (BANK_STRIDE)
  ) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_go  (load_go),
    .bank     (bank_sel),
    .mem_rd   (bus.mem_rd),
    .mem_addr (bus.mem_addr),
    .mem_data (bus.mem_data),
    .wr_en    (ld_wr_en),
    .wr_addr  (ld_wr_addr),
    .wr_data  (ld_wr_data),
    .done     (ld_done)
  );

  always_ff @(posedge clk) begin
    if (ld_wr_en) begin
      pat_mem[ld_wr_addr] <= ld_wr_data;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    vidx_next      = vidx_reg;
    timer_next     = timer_reg;
    gcnt_next      = gcnt_reg;
    round_len_next = round_len_reg;
    score_next     = score_reg;
    echo_sym_next  = echo_sym_reg;
    echo_flag_next = echo_flag_reg;

    case (state_reg)
      ST_IDLE, ST_LOSE, ST_DONE: begin
        if (start) begin
          state_next     = ST_LOAD;
          score_next     = '0;
          echo_sym_next  = '0;
          echo_flag_next = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_done) begin
          state_next     = ST_SHOW_OFF;
          round_len_next = START_LEN_C;
          idx_next       = '0;
        end
      end
      ST_SHOW_OFF: begin
        if (tick) begin
          state_next = ST_SHOW_ON;
        end
      end
      ST_SHOW_ON: begin
        if (tick) begin
          if ((idx_reg + 1'b1) < round_len_reg) begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_SHOW_OFF;
          end else begin
            vidx_next      = '0;
            timer_next     = {1'b0, round_len_reg} + TIME_C;
            echo_flag_next = 1'b0;
            state_next     = ST_INPUT;
          end
        end
      end
      ST_INPUT: begin
        // a press takes priority; a coincident tick is dropped entirely
        if (bus.btn_valid) begin
          if (bus.btn_code == pat_mem[vidx_reg]) begin
            echo_sym_next  = bus.btn_code;
            echo_flag_next = 1'b1;
            if ((vidx_reg + 1'b1) == round_len_reg) begin
              score_next = round_len_reg;
              gcnt_next  = GOOD_C;
              state_next = ST_GOOD;
            end else begin
              vidx_next = vidx_reg + 1'b1;
            end
          end else begin
            state_next = ST_LOSE;
          end
        end else if (tick) begin
          if (timer_reg == '0) begin
            state_next = ST_LOSE;
          end else begin
            timer_next = timer_reg - 1'b1;
          end
        end
      end
      ST_GOOD: begin
        // gcnt counts the ticks still to hold; the last one leaves GOOD
        if (tick) begin
          if (gcnt_reg <= GCNT_W'(1)) begin
            if (round_len_reg == PAT_LEN_C) begin
              state_next = ST_DONE;
            end else begin
              round_len_next = round_len_reg + 1'b1;
              idx_next       = '0;
              state_next     = ST_SHOW_OFF;
            end
          end else begin
            gcnt_next = gcnt_reg - 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      vidx_reg      <= '0;
      timer_reg     <= '0;
      gcnt_reg      <= '0;
      round_len_reg <= '0;
      score_reg     <= '0;
      echo_sym_reg  <= '0;
      echo_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      vidx_reg      <= vidx_next;
      timer_reg     <= timer_next;
      gcnt_reg      <= gcnt_next;
      round_len_reg <= round_len_next;
      score_reg     <= score_next;
      echo_sym_reg  <= echo_sym_next;
      echo_flag_reg <= echo_flag_next;
    end
  end

  always_comb begin
    msg_sel = MSG_BLANK;
    case (state_reg)
      ST_INPUT:         msg_sel = echo_flag_reg ? MSG_ECHO : MSG_BLANK;
      ST_GOOD, ST_DONE: msg_sel = MSG_GOOD;
      ST_LOSE:          msg_sel = MSG_LOSE;
      default:          msg_sel = MSG_BLANK;
    endcase
  end

  assign show_en   = (state_reg == ST_SHOW_ON);
  assign show_sym  = show_en ? pat_mem[idx_reg] : echo_sym_reg;
  assign round_len = round_len_reg;
  assign score     = score_reg;
  assign busy      = state_is_busy(state_reg);
  assign game_over = (state_reg == ST_LOSE) || (state_reg == ST_DONE);

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;
  import round_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              tick = 1'b0;
  logic [BANK_W-1:0] bank_sel = '0;
  logic              show_en;
  logic [SYM_W-1:0]  show_sym;
  logic [1:0]        msg_sel;
  logic [IDX_W-1:0]  round_len;
  logic [IDX_W-1:0]  score;
  logic              busy;
  logic              game_over;

  int pass_cnt  = 0;
  int total_cnt = 0;

  round_sequencer_if bus();

  round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bank_sel  (bank_sel),
    .tick      (tick),
    .bus       (bus),
    .show_en   (show_en),
    .show_sym  (show_sym),
    .msg_sel   (msg_sel),
    .round_len (round_len),
    .score     (score),
    .busy      (busy),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // block memory model: one-cycle read latency, data = addr[2:0] mod 5
  function automatic logic [SYM_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
    logic [2:0] lo;
    lo = a[2:0];
    return SYM_W'(lo % 3'd5);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem_model(bus.mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    $display("[%0t] tick      msg=%0d show_en=%0d sym=%0d len=%0d score=%0d", $time, msg_sel, show_en, show_sym, round_len, score);
  endtask

  task automatic press(input logic [SYM_W-1:0] code, input logic with_tick);
    bus.btn_valid = 1'b1;
    bus.btn_code  = code;
    tick          = with_tick;
    cyc();
    bus.btn_valid = 1'b0;
    tick          = 1'b0;
    $display("[%0t] press %0d t=%0d msg=%0d sym=%0d score=%0d over=%0d", $time, code, with_tick, msg_sel, show_sym, score, game_over);
  endtask

  task automatic pulse_start(input logic [BANK_W-1:0] b);
    bank_sel = b;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    $display("[%0t] start bank=%0d busy=%0d mem_rd=%0d addr=%0d", $time, b, busy, bus.mem_rd, bus.mem_addr);
  endtask

  // start plus the full load; returns in SHOW_OFF of round 1
  task automatic start_and_load(input logic [BANK_W-1:0] b);
    pulse_start(b);
    repeat (51) cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"},    bus.mem_rd,   1'b0);
    check({tag, "_mem_addr"},  bus.mem_addr, 0);
    check({tag, "_show_en"},   show_en,      1'b0);
    check({tag, "_show_sym"},  show_sym,     0);
    check({tag, "_msg"},       msg_sel,      MSG_BLANK);
    check({tag, "_round_len"}, round_len,    0);
    check({tag, "_score"},     score,        0);
    check({tag, "_busy"},      busy,         1'b0);
    check({tag, "_game_over"}, game_over,    1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_valid = 1'b0;
    bus.btn_code  = '0;

    // reset state
    cyc();
    cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // 1: load from bank 2 -> addresses 100..149, one per cycle
    pulse_start(2'd2);
    check("load_busy", busy, 1'b1);
    for (int k = 0; k < 50; k++) begin
      check("load_rd", bus.mem_rd, 1'b1);
      check("load_addr", bus.mem_addr, 100 + k);
      cyc();
    end
    check("load_rd_end", bus.mem_rd, 1'b0);
    check("load_still_busy", busy, 1'b1);
    cyc();
    check("r1_len", round_len, 1);
    check("r1_show_off", show_en, 1'b0);

    // 2: round 1 shows pat[0]=4 after one blank tick, then correct press
    do_tick();
    check("r1_show_on", show_en, 1'b1);
    check("r1_sym0", show_sym, 4);
    do_tick();
    check("r1_input_show_en", show_en, 1'b0);
    check("r1_input_msg", msg_sel, MSG_BLANK);
    check("r1_input_over", game_over, 1'b0);
    press(SYM_MID, 1'b0);
    check("r1_good_msg", msg_sel, MSG_GOOD);
    check("r1_score", score, 1);
    check("r1_good_sym", show_sym, 4);
    do_tick();
    check("r1_good_hold", msg_sel, MSG_GOOD);
    do_tick();
    check("r2_msg_blank", msg_sel, MSG_BLANK);
    check("r2_len", round_len, 2);
    check("r2_show_off", show_en, 1'b0);

    // start and presses during SHOW are ignored
    pulse_start(2'd1);
    check("show_start_rd", bus.mem_rd, 1'b0);
    check("show_start_len", round_len, 2);
    check("show_start_busy", busy, 1'b1);
    press(SYM_RIGHT, 1'b0);
    check("show_btn_over", game_over, 1'b0);
    check("show_btn_msg", msg_sel, MSG_BLANK);

    // 3: round 2 shows 4 then 0; first press correct, second wrong
    do_tick();
    check("r2_sym0", show_sym, 4);
    do_tick();
    check("r2_gap", show_en, 1'b0);
    do_tick();
    check("r2_sym1_en", show_en, 1'b1);
    check("r2_sym1", show_sym, 0);
    do_tick();
    press(SYM_MID, 1'b0);
    check("r2_echo_msg", msg_sel, MSG_ECHO);
    check("r2_echo_sym", show_sym, 4);
    check("r2_echo_busy", busy, 1'b1);
    press(SYM_DOWN, 1'b0);
    check("r2_lose_msg", msg_sel, MSG_LOSE);
    check("r2_lose_over", game_over, 1'b1);
    check("r2_lose_score", score, 1);
    check("r2_lose_busy", busy, 1'b0);
    do_tick();
    press(SYM_UP, 1'b0);
    check("lose_frozen_msg", msg_sel, MSG_LOSE);
    check("lose_frozen_score", score, 1);

    // 4: round 1 with no press: timer 4, LOSE on the 5th INPUT tick
    start_and_load(2'd2);
    check("t4_score_clear", score, 0);
    check("t4_over_clear", game_over, 1'b0);
    do_tick();
    do_tick();
    repeat (4) do_tick();
    check("t4_tick4_busy", busy, 1'b1);
    check("t4_tick4_over", game_over, 1'b0);
    do_tick();
    check("t4_tick5_over", game_over, 1'b1);
    check("t4_tick5_msg", msg_sel, MSG_LOSE);

    // 5: final correct press coincides with the expiring tick
    start_and_load(2'd2);
    do_tick();
    do_tick();
    repeat (4) do_tick();
    press(SYM_MID, 1'b1);
    check("t5_msg", msg_sel, MSG_GOOD);
    check("t5_over", game_over, 1'b0);
    check("t5_score", score, 1);
    pulse_start(2'd0);
    check("t5_start_ignored_msg", msg_sel, MSG_GOOD);
    check("t5_start_ignored_rd", bus.mem_rd, 1'b0);

    // 6: reset from GOOD, then reset in the middle of a load
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_all_zero("rst_good");
    pulse_start(2'd3);
    check("b3_addr0", bus.mem_addr, 150);
    repeat (3) cyc();
    check("b3_addr3", bus.mem_addr, 153);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_all_zero("rst_load");
    cyc();
    check("abandon_rd", bus.mem_rd, 1'b0);
    check("abandon_busy", busy, 1'b0);

    // bank 1 base address and its first symbol ((50&7)%5 = 2)
    pulse_start(2'd1);
    check("b1_addr0", bus.mem_addr, 50);
    repeat (51) cyc();
    do_tick();
    check("b1_sym0", show_sym, 2);
    check("b1_len", round_len, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
